bus_read_sequencer: RTL
=======================

// Module: bus_read_sequencer
// PURPOSE
//  Reader end of the shared tri-state register bus. Registers place data on the bus only while their OE is high.
//  This block asserts one OE at a time, waits for the bus to settle, and samples it.
//  Each captured word is presented downstream with a valid/ready handshake.
//  Sits between the register bank and the accelerator datapath/controller.
// PARAMETERS
//  DATA_W        10  bus / register data width
//  NUM_REGS       4  number of bus-attached registers (OE lines)
//  SETTLE_CYCLES  1  extra cycles OE is held before sampling (>=0)
// PORTS
//  Clk        in   1                         single system clock, rising edge
//  MR         in   1                         master reset, asynchronous, active-low
//  start      in   1                         begin read sequence (honoured only in IDLE)
//  count      in   $clog2(NUM_REGS+1)        registers to read, index 0..count-1
//  OE         out  NUM_REGS                  one-hot output enables to the registers
//  bus_in     in   DATA_W                    shared tri-state bus
//  out_data   out  DATA_W                    captured word
//  out_idx    out  $clog2(NUM_REGS)          register index of out_data
//  out_valid  out  1                         out_data valid
//  out_ready  in   1                         downstream accepts
//  busy       out  1                         sequence in progress
//  done       out  1                         1-cycle pulse, sequence complete
// BEHAVIOUR
//  - Reset (MR=0, async): OE=0, out_valid=0, busy=0, done=0, out_data=0, out_idx=0, state IDLE. Takes effect immediately, mid-read included.
//  - FSM states: IDLE -> DRIVE -> HOLD -> (DRIVE for next idx | FINISH) -> IDLE.
//  - IDLE: on start, latch count, clamped to NUM_REGS; idx=0.
//    - count!=0: go to DRIVE.
//    - count==0: go to FINISH; no OE is ever raised.
//  - DRIVE: OE[idx]=1 and all other OE bits 0, held for exactly SETTLE_CYCLES+1 cycles.
//    - bus_in is sampled on the edge that ends the last DRIVE cycle; the FSM then goes to HOLD.
//  - HOLD: OE=0 (break-before-make: at least 1 all-zero OE cycle between any two reads).
//    - out_valid=1; out_data/out_idx held stable until the out_valid && out_ready handshake.
//  - On the handshake cycle: if idx==count-1 go to FINISH, else idx++ and go to DRIVE next cycle.
//  - FINISH: done=1 for one cycle, busy=0 from the next cycle, then IDLE.
//  - busy=1 from the cycle after start through the FINISH cycle inclusive.
//  - start while busy is ignored; a count change mid-sequence has no effect.
//  - Latency, SETTLE_CYCLES=S, start at cycle 0, out_ready tied high:
//    - OE[0] high in cycles 1..1+S; out_valid in cycle 2+S.
//    - The next OE rises at cycle 3+S.
//  - OE is never multi-hot, including across reset release.
// CONFIGURATION
//  READ_CHECKSUM_EN defined:
//    - extra output `checksum [DATA_W-1:0]`: sum mod 2^DATA_W of every captured word in the current sequence.
//    - Cleared when start is accepted; final value valid while done=1 and held until the next start.
//    - Reset value 0.
//  READ_CHECKSUM_EN undefined: no checksum port or logic; all other behaviour is identical.
// STRUCTURE
//  - Package mm_bus_pkg holds:
//    - the state enum (IDLE, DRIVE, HOLD, FINISH);
//    - the default DATA_W/NUM_REGS constants;
//    - the index-width helper function.
//  - Sub-module oe_onehot_decoder: index plus enable -> NUM_REGS one-hot OE, all-zero when disabled.
//  - Settle counter, index counter and capture register live in the top level.
// TESTING
//  1 Reset: MR low mid-DRIVE (OE[2]=1) -> OE=0, out_valid=0, busy=0 in the same cycle; no done pulse.
//  2 Basic: S=1, regs hold 10'h001,10'h155,10'h2AA,10'h3FF, count=4, ready=1.
//    - Outputs in order idx0..3 with matching data; OE[i] high 2 cycles each; done once.
//  3 Backpressure: ready low 5 cycles on idx1.
//    - out_data stays 10'h155 and out_valid stays 1 throughout; OE stays 0; idx2 read only after the handshake.
//  4 Boundaries:
//    - count=0 -> done in the cycle after start, OE never asserted.
//    - count=7 (NUM_REGS=4) -> exactly 4 reads.
//  5 Start while busy: second start during idx1 -> ignored; sequence completes with one done.
//  6 READ_CHECKSUM_EN, data of test 2 -> checksum = 10'h3FF at done (sum 0x7FF mod 2^10).
//    - Macro undefined: the same run produces the same outputs as test 2.
//  Checker all tests: OE one-hot or zero every cycle; >=1 zero cycle between consecutive OE pulses.

Source files
------------

// File: rtl/mm_bus_pkg.sv
// Shared definitions for the register-bus reader: FSM state encoding,
// default geometry and the index-width helper.
package mm_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    HOLD,
    FINISH
  } rd_state_t;

  localparam int DEF_DATA_W        = 10;
  localparam int DEF_NUM_REGS      = 4;
  localparam int DEF_SETTLE_CYCLES = 1;

  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/oe_onehot_decoder.sv
// Index plus enable to one-hot output-enable vector; all-zero when disabled.
module oe_onehot_decoder #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [IW-1:0] idx,
  input  logic          en,
  output logic [N-1:0]  oe
);

  always_comb begin
    oe = '0;
    if (en) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (idx == IW'(i)) oe[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_read_sequencer.sv
// Reader end of the shared tri-state register bus: one OE at a time, settle,
// sample, hand the word downstream over valid/ready.
// Optional running checksum output enabled by defining READ_CHECKSUM_EN.
module bus_read_sequencer
  import mm_bus_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int NUM_REGS      = DEF_NUM_REGS,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                                Clk,
  input  logic                                MR,
  input  logic                                start,
  input  logic [$clog2(NUM_REGS+1)-1:0]       count,
  output logic [NUM_REGS-1:0]                 OE,
  input  logic [DATA_W-1:0]                   bus_in,
  output logic [DATA_W-1:0]                   out_data,
  output logic [idx_width(NUM_REGS)-1:0]      out_idx,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy,
  output logic                                done
`ifdef READ_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]                   checksum
`endif
);

  localparam int CW = $clog2(NUM_REGS + 1);
  localparam int IW = idx_width(NUM_REGS);
  localparam int SW = idx_width(SETTLE_CYCLES + 1);

  rd_state_t      state;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  last_idx;
  logic [SW-1:0]  settle_cnt;
  logic [CW-1:0]  count_clamped;
  logic [IW-1:0]  last_idx_in;

  assign count_clamped = (count > CW'(NUM_REGS)) ? CW'(NUM_REGS) : count;
  assign last_idx_in   = IW'(count_clamped - CW'(1));

  // OE decodes straight from state/idx flops, so it is zero in IDLE and
  // cannot go multi-hot across reset release.
  oe_onehot_decoder #(
    .N  (NUM_REGS),
    .IW (IW)
  ) u_oe_dec (
    .idx (idx),
    .en  (state == DRIVE),
    .oe  (OE)
  );

  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      state      <= IDLE;
      idx        <= '0;
      last_idx   <= '0;
      settle_cnt <= '0;
      out_data   <= '0;
      out_idx    <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef READ_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            idx        <= '0;
            last_idx   <= last_idx_in;
            settle_cnt <= '0;
`ifdef READ_CHECKSUM_EN
            checksum   <= '0;
`endif
            if (count_clamped != '0) begin
              state <= DRIVE;
            end else begin
              state <= FINISH;
              done  <= 1'b1;
            end
          end
        end
        DRIVE: begin
          if (settle_cnt == SW'(SETTLE_CYCLES)) begin
            out_data  <= bus_in;
            out_idx   <= idx;
            out_valid <= 1'b1;
`ifdef READ_CHECKSUM_EN
            checksum  <= checksum + bus_in;
`endif
            state     <= HOLD;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == last_idx) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              idx        <= idx + 1'b1;
              settle_cnt <= '0;
              state      <= DRIVE;
            end
          end
        end
        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
